// File: rtl/proc_quantum_scheduler_pkg.sv
// Shared types and constants for the preemptive round-robin process scheduler.
package sched_pkg;

    // Scheduler control states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SELECT = 2'd2,
        ST_REQ    = 2'd3
    } sched_state_e;

    // Configuration port write targets; value 3 is reserved and ignored.
    localparam logic [1:0] CFG_QUANTUM = 2'd0;
    localparam logic [1:0] CFG_READY   = 2'd1;
    localparam logic [1:0] CFG_YIELD   = 2'd2;

    // Default geometry.
    localparam int DEF_NPROC   = 8;
    localparam int DEF_QW      = 16;
    localparam int DEF_QUANTUM = 1000;

endpackage

// File: rtl/proc_quantum_scheduler_if.sv
// Kernel configuration port plus the switch handshake toward the process-swap logic.
interface proc_quantum_scheduler_if #(
    parameter int NPROC = 8,
    parameter int QW    = 16
);
    logic                     cfg_we;
    logic [1:0]               cfg_sel;
    logic [31:0]              cfg_data;
    logic                     preempt_req;
    logic                     preempt_ack;
    logic [$clog2(NPROC)-1:0] next_proc;

    // Kernel / swap-logic side.
    modport master (
        output cfg_we, cfg_sel, cfg_data, preempt_ack,
        input  preempt_req, next_proc
    );

    // Scheduler side.
    modport slave (
        input  cfg_we, cfg_sel, cfg_data, preempt_ack,
        output preempt_req, next_proc
    );
endinterface

// File: rtl/proc_quantum_scheduler_rr_picker.sv
// Combinational round-robin finder over the user slots (1..NPROC-1).
// Searches cur+1..NPROC-1, then wraps to 1..cur; slot 0 is never returned as a hit.
module rr_picker #(
    parameter int NPROC = 8,
    parameter int IW    = $clog2(NPROC)
) (
    input  logic [NPROC-1:0] mask,
    input  logic [IW-1:0]    cur,
    output logic [IW-1:0]    idx,
    output logic             found
);
    logic take_s;
    logic unused_mask_s;

    // Slot 0 is the OS fallback and is handled by the caller.
    assign unused_mask_s = mask[0];

    // First pass above the current slot, second pass wraps up to and including it.
    always_comb begin
        idx    = {IW{1'b0}};
        found  = 1'b0;
        take_s = 1'b0;
        for (int i = 1; i < NPROC; i++) begin
            take_s = !found && mask[i] && (i > int'(cur));
            idx    = take_s ? IW'(i) : idx;
            found  = found | take_s;
        end
        for (int i = 1; i < NPROC; i++) begin
            take_s = !found && mask[i] && (i <= int'(cur));
            idx    = take_s ? IW'(i) : idx;
            found  = found | take_s;
        end
    end
endmodule

// File: rtl/proc_quantum_scheduler.sv
// Preemptive round-robin scheduler: counts retired steps against a quantum,
// picks the next ready process and holds a switch request until acknowledged.
module proc_quantum_scheduler
    import sched_pkg::*;
#(
    parameter int NPROC       = DEF_NPROC,
    parameter int QW          = DEF_QW,
    parameter int DEF_QUANTUM = sched_pkg::DEF_QUANTUM,
    parameter int IW          = $clog2(NPROC)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      step,
    input  logic                      proc_exit,
    proc_quantum_scheduler_if.slave   bus,
    output logic [IW-1:0]             cur_proc,
    output logic [QW-1:0]             quantum_left,
    output logic                      idle
);
    localparam logic [NPROC-1:0] OS_BIT = {{(NPROC-1){1'b0}}, 1'b1};

    // Slot 0 can never be made unready.
    function automatic logic [NPROC-1:0] force_os_ready(input logic [NPROC-1:0] m);
        return m | OS_BIT;
    endfunction

    sched_state_e      state_r, state_next_s;
    logic [IW-1:0]     cur_proc_r, cur_proc_next_s;
    logic [IW-1:0]     next_proc_r, next_proc_next_s;
    logic              preempt_req_r, preempt_req_next_s;
    logic [QW-1:0]     quantum_reg_r, quantum_reg_next_s;
    logic [QW-1:0]     quantum_left_r, quantum_left_next_s;
    logic [NPROC-1:0]  ready_r, ready_base_s, ready_next_s, exit_clear_s;
    logic              idle_r, idle_next_s;
    logic              cfg_quantum_s, cfg_ready_s, cfg_yield_s;
    logic              exit_s, expire_s;
    logic [IW-1:0]     pick_idx_s, pick_sel_s;
    logic              pick_found_s;
    logic              unused_cfg_bits_s;

    assign unused_cfg_bits_s = ^bus.cfg_data[31:QW];

    assign cfg_quantum_s = bus.cfg_we && (bus.cfg_sel == CFG_QUANTUM);
    assign cfg_ready_s   = bus.cfg_we && (bus.cfg_sel == CFG_READY);
    assign cfg_yield_s   = bus.cfg_we && (bus.cfg_sel == CFG_YIELD);

    // An exit only matters for a user process that is actually running.
    assign exit_s       = (state_r == ST_RUN) && proc_exit && (cur_proc_r != {IW{1'b0}});
    assign expire_s     = step && (quantum_left_r == {{(QW-1){1'b0}}, 1'b1});
    assign exit_clear_s = NPROC'(exit_s) << cur_proc_r;

    // Next ready mask: kernel write first, then the exiting process drops out.
    always_comb begin
        ready_base_s = cfg_ready_s ? force_os_ready(bus.cfg_data[NPROC-1:0]) : ready_r;
        ready_next_s = force_os_ready(ready_base_s & ~exit_clear_s);
        idle_next_s  = (ready_next_s[NPROC-1:1] == {(NPROC-1){1'b0}});
    end

    assign quantum_reg_next_s = cfg_quantum_s ? bus.cfg_data[QW-1:0] : quantum_reg_r;

    // The picker sees the next-state mask so a write during SELECT affects the pick.
    rr_picker #(.NPROC(NPROC), .IW(IW)) u_picker (
        .mask  (ready_next_s),
        .cur   (cur_proc_r),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    assign pick_sel_s = pick_found_s ? pick_idx_s : {IW{1'b0}};

    // Next-state and datapath update for the scheduling FSM.
    always_comb begin
        state_next_s        = state_r;
        cur_proc_next_s     = cur_proc_r;
        next_proc_next_s    = next_proc_r;
        preempt_req_next_s  = preempt_req_r;
        quantum_left_next_s = quantum_left_r;
        case (state_r)
            ST_IDLE: begin
                preempt_req_next_s = 1'b0;
                if (enable) begin
                    state_next_s        = ST_RUN;
                    quantum_left_next_s = quantum_reg_r;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_next_s = ST_IDLE;
                end else begin
                    if (step && (quantum_left_r != {QW{1'b0}})) begin
                        quantum_left_next_s = quantum_left_r - {{(QW-1){1'b0}}, 1'b1};
                    end else begin
                        quantum_left_next_s = quantum_left_r;
                    end
                    if (cfg_yield_s || exit_s || !ready_next_s[cur_proc_r] || expire_s) begin
                        state_next_s = ST_SELECT;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
            end
            ST_SELECT: begin
                if (!enable) begin
                    state_next_s = ST_IDLE;
                end else if (pick_sel_s == cur_proc_r) begin
                    state_next_s        = ST_RUN;
                    quantum_left_next_s = quantum_reg_r;
                end else begin
                    state_next_s       = ST_REQ;
                    next_proc_next_s   = pick_sel_s;
                    preempt_req_next_s = 1'b1;
                end
            end
            ST_REQ: begin
                if (!enable) begin
                    state_next_s       = ST_IDLE;
                    preempt_req_next_s = 1'b0;
                end else if (bus.preempt_ack) begin
                    state_next_s        = ST_RUN;
                    cur_proc_next_s     = next_proc_r;
                    quantum_left_next_s = quantum_reg_r;
                    preempt_req_next_s  = 1'b0;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            default: begin
                state_next_s       = ST_IDLE;
                preempt_req_next_s = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            cur_proc_r     <= {IW{1'b0}};
            next_proc_r    <= {IW{1'b0}};
            preempt_req_r  <= 1'b0;
            quantum_reg_r  <= QW'(DEF_QUANTUM);
            quantum_left_r <= QW'(DEF_QUANTUM);
            ready_r        <= OS_BIT;
            idle_r         <= 1'b1;
        end else begin
            state_r        <= state_next_s;
            cur_proc_r     <= cur_proc_next_s;
            next_proc_r    <= next_proc_next_s;
            preempt_req_r  <= preempt_req_next_s;
            quantum_reg_r  <= quantum_reg_next_s;
            quantum_left_r <= quantum_left_next_s;
            ready_r        <= ready_next_s;
            idle_r         <= idle_next_s;
        end
    end

    assign cur_proc        = cur_proc_r;
    assign quantum_left    = quantum_left_r;
    assign idle            = idle_r;
    assign bus.preempt_req = preempt_req_r;
    assign bus.next_proc   = next_proc_r;
endmodule

// File: tb/tb_proc_quantum_scheduler.sv
// Directed bench for proc_quantum_scheduler with a next_proc scoreboard.
module tb_proc_quantum_scheduler;
    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        step;
    logic        proc_exit;
    logic [2:0]  cur_proc;
    logic [15:0] quantum_left;
    logic        idle;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clock = ~clock;

    proc_quantum_scheduler_if #(.NPROC(8), .QW(16)) bus_if ();

    proc_quantum_scheduler #(.NPROC(8), .QW(16), .DEF_QUANTUM(1000)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .step         (step),
        .proc_exit    (proc_exit),
        .bus          (bus_if.slave),
        .cur_proc     (cur_proc),
        .quantum_left (quantum_left),
        .idle         (idle)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_steps(input int n);
        step = 1'b1;
        repeat (n) tick();
        step = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [31:0] data);
        bus_if.cfg_we   = 1'b1;
        bus_if.cfg_sel  = sel;
        bus_if.cfg_data = data;
        tick();
        bus_if.cfg_we   = 1'b0;
        bus_if.cfg_data = 32'd0;
    endtask

    // Bounded wait for preempt_req, then scoreboard compare of next_proc.
    task automatic wait_req(input string tag, input int budget, output int waited);
        int exp;
        waited = 0;
        while (bus_if.preempt_req !== 1'b1 && waited < budget) begin
            tick();
            waited++;
        end
        check({tag, "_req"}, {31'd0, bus_if.preempt_req}, 32'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check({tag, "_next"}, {29'd0, bus_if.next_proc}, exp);
    endtask

    task automatic do_ack();
        bus_if.preempt_ack = 1'b1;
        tick();
        bus_if.preempt_ack = 1'b0;
    endtask

    task automatic watch_no_req(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            tick();
            seen = seen | (bus_if.preempt_req !== 1'b0);
        end
        check(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        int waited;
        logic seen;
        reset = 1'b0; enable = 1'b0; step = 1'b0; proc_exit = 1'b0;
        bus_if.cfg_we = 1'b0; bus_if.cfg_sel = 2'd0; bus_if.cfg_data = 32'd0;
        bus_if.preempt_ack = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_req", {31'd0, bus_if.preempt_req}, 32'd0);
        check("rst_cur", {29'd0, cur_proc}, 32'd0);
        check("rst_next", {29'd0, bus_if.next_proc}, 32'd0);
        check("rst_qleft", {16'd0, quantum_left}, 32'd1000);
        check("rst_idle", {31'd0, idle}, 32'd1);
        reset = 1'b1;
        tick();

        // Basic expiry: quantum 3, mask 0b110, cur 0.
        cfg_write(2'd0, 32'd3);
        cfg_write(2'd1, 32'h06);
        check("idle_clear", {31'd0, idle}, 32'd0);
        check("qleft_no_reload", {16'd0, quantum_left}, 32'd1000);
        enable = 1'b1;
        tick();
        check("qleft_enter_run", {16'd0, quantum_left}, 32'd3);
        exp_q.push_back(1);
        do_steps(3);
        check("req_not_yet", {31'd0, bus_if.preempt_req}, 32'd0);
        wait_req("exp1", 10, waited);
        check("exp1_latency", waited, 32'd1);
        do_ack();
        check("ack1_cur", {29'd0, cur_proc}, 32'd1);
        check("ack1_qleft", {16'd0, quantum_left}, 32'd3);
        check("ack1_req_drop", {31'd0, bus_if.preempt_req}, 32'd0);

        // Clearing cur's ready bit forces a pick; then 2 -> 7 -> wrap to 2.
        exp_q.push_back(2);
        cfg_write(2'd1, 32'h85);
        wait_req("mask_clr", 10, waited);
        do_ack();
        check("cur2", {29'd0, cur_proc}, 32'd2);
        exp_q.push_back(7);
        do_steps(3);
        wait_req("to7", 10, waited);
        do_ack();
        exp_q.push_back(2);
        do_steps(3);
        wait_req("wrap2", 10, waited);
        do_ack();

        // Only OS ready: move to 0, then expiry reloads without a request.
        exp_q.push_back(0);
        cfg_write(2'd1, 32'h01);
        wait_req("to_os", 10, waited);
        do_ack();
        check("os_cur", {29'd0, cur_proc}, 32'd0);
        check("os_idle", {31'd0, idle}, 32'd1);
        do_steps(3);
        tick();
        check("os_reload", {16'd0, quantum_left}, 32'd3);
        watch_no_req("os_no_req", 6);

        // Exit and final step together at cur=1.
        cfg_write(2'd1, 32'h06);
        exp_q.push_back(1);
        cfg_write(2'd2, 32'd0);
        wait_req("yield1", 10, waited);
        do_ack();
        do_steps(2);
        exp_q.push_back(2);
        step = 1'b1; proc_exit = 1'b1;
        tick();
        step = 1'b0; proc_exit = 1'b0;
        wait_req("exit", 10, waited);
        do_ack();
        check("exit_cur", {29'd0, cur_proc}, 32'd2);
        watch_no_req("exit_single", 3);

        // Quantum 0; a yield at cur=2 reselects 2 itself (slot 1 gone).
        cfg_write(2'd0, 32'd0);
        cfg_write(2'd2, 32'd0);
        watch_no_req("mask_bit1_gone", 4);
        check("q0_cur", {29'd0, cur_proc}, 32'd2);
        check("q0_qleft", {16'd0, quantum_left}, 32'd0);
        seen = 1'b0;
        step = 1'b1;
        repeat (5000) begin
            tick();
            seen = seen | (bus_if.preempt_req !== 1'b0);
        end
        step = 1'b0;
        check("q0_no_req", {31'd0, seen}, 32'd0);
        check("q0_hold", {16'd0, quantum_left}, 32'd0);
        cfg_write(2'd1, 32'h14);
        exp_q.push_back(4);
        cfg_write(2'd2, 32'd0);
        wait_req("q0_yield", 10, waited);

        // Asynchronous reset while the request is pending.
        reset = 1'b0;
        #1;
        check("arst_req", {31'd0, bus_if.preempt_req}, 32'd0);
        check("arst_cur", {29'd0, cur_proc}, 32'd0);
        check("arst_next", {29'd0, bus_if.next_proc}, 32'd0);
        check("arst_qleft", {16'd0, quantum_left}, 32'd1000);
        check("arst_idle", {31'd0, idle}, 32'd1);
        enable = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        do_steps(3);
        check("post_rst_idle_qleft", {16'd0, quantum_left}, 32'd1000);
        enable = 1'b1;
        tick();
        do_steps(1);
        check("post_rst_run", {16'd0, quantum_left}, 32'd999);
        check("post_rst_no_req", {31'd0, bus_if.preempt_req}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/proc_quantum_scheduler.md
# proc_quantum_scheduler

Preemptive round-robin process scheduler for the multi-process core. It counts retired instructions of the running process against a programmable quantum and picks the next ready process in round-robin order. It then raises a switch request to the process-swap logic (PROCESS_KEEPER and the PC/register save path) and holds it until acknowledged. The kernel configures the quantum and the ready mask through a small register port driven by its store path.

## Interface
Parameters:
- NPROC, 8: number of process slots; slot 0 is the OS and is always eligible.
- QW, 16: quantum counter width.
- DEF_QUANTUM, 1000: quantum loaded at reset.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  scheduling on; the kernel sets it after boot.
- step  in  1  one instruction retired this cycle.
- cfg_we  in  1  configuration write strobe.
- cfg_sel  in  2  write target: 0 = quantum, 1 = ready mask, 2 = yield. 3 is reserved; a write to it is ignored.
- cfg_data  in  32  write data. The quantum uses [QW-1:0]; the ready mask uses [NPROC-1:0].
- proc_exit  in  1  the running process terminated.
- preempt_ack  in  1  the swap logic has accepted next_proc.
- preempt_req  out  1  a switch is requested; held high until acknowledged.
- next_proc  out  clog2(NPROC)  target process; valid while preempt_req is high.
- cur_proc  out  clog2(NPROC)  running process index.
- quantum_left  out  QW  remaining steps for the running process.
- idle  out  1  the only ready process is slot 0.

## Operation
- States:
  - IDLE: disabled.
  - RUN: counting steps.
  - SELECT: one cycle to pick the next process.
  - REQ: waiting for acknowledgement.
- Reset values:
  - State IDLE; cur_proc 0; next_proc 0; preempt_req 0.
  - quantum_reg DEF_QUANTUM; quantum_left DEF_QUANTUM; ready mask 1 (slot 0 only); idle 1.
- IDLE -> RUN when enable=1. quantum_left is reloaded from quantum_reg on entry.
- RUN:
  - Each step decrements quantum_left.
  - A step taken with quantum_left==1 moves the block to SELECT.
  - A quantum_reg of 0 disables expiry: the block stays in RUN and quantum_left holds at 0.
- Yield (cfg_sel 2), proc_exit, or clearing cur_proc's ready bit also moves RUN to SELECT, regardless of the count.
- proc_exit clears ready[cur_proc] in the same cycle. proc_exit has no effect when cur_proc is 0, because slot 0 is always ready.
- SELECT picks the next process:
  - Search slots cur_proc+1 … NPROC-1, then wrap to 1 … cur_proc. Take the first set ready bit.
  - If no user slot is ready, select 0.
  - If the selection equals cur_proc: reload quantum_left and return to RUN. No request is raised.
  - Otherwise: latch next_proc and go to REQ.
- REQ:
  - preempt_req is high and next_proc is stable.
  - When preempt_ack=1: cur_proc <= next_proc, quantum_left <= quantum_reg, preempt_req drops, and the block goes to RUN.
  - preempt_ack outside REQ is ignored.
- Configuration writes:
  - A quantum write updates quantum_reg only. It takes effect at the next reload.
  - A ready-mask write takes effect immediately, with bit 0 forced to 1.
- enable=0 in any state sends the block to IDLE on the next cycle and drops preempt_req. cur_proc is kept.
- Steps are ignored outside RUN.
- idle = (ready[NPROC-1:1]==0). It is registered.

## Timing
- Expiry latency:
  - The last step is sampled at edge t; the state is SELECT after t.
  - preempt_req is high after edge t+1.
  - The earliest switch is at edge t+2, with ack high during the cycle before it.
- All outputs are registered. There is no combinational path from any input to any output.
- Simultaneous events in RUN:
  - proc_exit, yield and expiry in the same cycle produce exactly one SELECT.
  - The exit still clears the ready bit.
- A ready-mask write in SELECT is visible to that same pick: the picker uses the next-state mask.
- A ready-mask write that clears next_proc while in REQ does not withdraw the request. The kernel handles that case after the switch.
- Asynchronous reset mid-request drops preempt_req immediately. All outputs return to their reset values.

## Structure
- Package sched_pkg holds:
  - The state enum.
  - The cfg_sel constants: CFG_QUANTUM, CFG_READY, CFG_YIELD.
  - Default NPROC/QW values.
- Sub-module rr_picker: a combinational round-robin finder.
  - Inputs: mask, current index.
  - Outputs: index, found.
  - The FSM, counter and registers are in the top module.

## Test plan
- Quantum 3, ready mask 0b0000_0110, cur 0, enable: after 3 steps preempt_req rises with next_proc=1. Ack gives cur_proc=1 and quantum_left=3.
- From cur=2 with mask 0b1000_0101: expiry gives next_proc=7; the following expiry wraps to next_proc=2.
- Mask 0b0000_0001 with cur=0: expiry never raises preempt_req. quantum_left reloads and idle=1.
- proc_exit and the final step in the same cycle at cur=1, mask 0b110: one request with next_proc=2, and the mask becomes 0b100.
- Quantum 0: 5000 steps cause no request. A yield write then gives preempt_req with the next ready process.
- Reset driven low while in REQ: preempt_req=0 asynchronously, cur_proc=0, quantum_left=DEF_QUANTUM; after release the state is IDLE.
